// File: rtl/adf4030_trig_pkg.sv
// Shared state encoding and helpers for the ADF4030 trigger scheduler.
// No timing of its own; used by the channel FSM and the top-level packer.
package adf4030_trig_pkg;

   localparam int MAX_CHANNELS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      COUNT = 3'd2,
      FIRE  = 3'd3,
      ERR   = 3'd4
   } trig_state_t;

   // A channel counts as busy while it owns a pending or in-flight trigger.
   function automatic logic is_active(input trig_state_t s);
      return (s == ARMED) || (s == COUNT) || (s == FIRE);
   endfunction

endpackage

// File: rtl/adf4030_trig_channel.sv
// One trigger channel: arm, latch phase on bsync, count down, emit a single-cycle pulse.
// Pulse lands 1+phase cycles after the sampled bsync; no backpressure, bsync during COUNT/FIRE is dropped.
module adf4030_trig_channel
   import adf4030_trig_pkg::*;
#(
   parameter int PHASE_WIDTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_en,
   input  logic                   i_select_trig,
   input  logic                   i_man_edge,
   input  logic                   i_bsync,
   input  logic [PHASE_WIDTH-1:0] i_bsync_ratio,
   input  logic [PHASE_WIDTH-1:0] i_phase,
   output logic                   o_trig,
   output trig_state_t            o_state,
   output logic                   o_phase_error
);

   localparam logic [PHASE_WIDTH:0]   LIMIT_OFS = (PHASE_WIDTH+1)'(2);
   localparam logic [PHASE_WIDTH-1:0] CNT_ONE   = PHASE_WIDTH'(1);

   trig_state_t            r_state;
   trig_state_t            w_state_nxt;
   logic [PHASE_WIDTH-1:0] r_cnt;
   logic [PHASE_WIDTH-1:0] w_cnt_nxt;
   logic [PHASE_WIDTH:0]   w_phase_limit;
   logic                   w_phase_bad;
   logic                   w_arm_req;

   // Last legal phase is 2*ratio-2 so the pulse lands before the next bsync; ratio 0 has none.
   assign w_phase_limit = {i_bsync_ratio, 1'b0} - LIMIT_OFS;
   assign w_phase_bad   = (i_bsync_ratio == '0) || ({1'b0, i_phase} > w_phase_limit);
   assign w_arm_req     = i_select_trig ? i_man_edge : 1'b1;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!i_en) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_arm_req) w_state_nxt = ARMED;
            end
            ARMED: begin
               if (i_bsync) begin
                  if (w_phase_bad) begin
                     w_state_nxt = ERR;
                  end else begin
                     w_cnt_nxt   = i_phase;
                     w_state_nxt = (i_phase == '0) ? FIRE : COUNT;
                  end
               end
            end
            COUNT: begin
               w_cnt_nxt = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) w_state_nxt = FIRE;
            end
            FIRE: begin
               w_state_nxt = i_select_trig ? IDLE : ARMED;
            end
            ERR: begin
               w_state_nxt = ERR;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign o_trig        = (r_state == FIRE);
   assign o_state       = r_state;
   assign o_phase_error = (r_state == ERR);

endmodule

// File: rtl/adf4030_trig_scheduler.sv
// Core-side ADF4030 trigger scheduler: shared manual edge detect, per-channel FSMs, busy reduce.
// Pulse 1+phase cycles after bsync, busy one cycle behind state; no backpressure, inputs always accepted.
module adf4030_trig_scheduler
   import adf4030_trig_pkg::*;
#(
   parameter int CHANNEL_COUNT = 1,
   parameter int PHASE_WIDTH   = 16
) (
   input  logic                                      i_clk,
   input  logic                                      i_rstn,
   input  logic                                      i_bsync,
   input  logic [PHASE_WIDTH-1:0]                    i_bsync_ratio,
   input  logic [CHANNEL_COUNT-1:0]                  i_trig_channel_en,
   input  logic [CHANNEL_COUNT-1:0][PHASE_WIDTH-1:0] i_trig_channel_phase,
   input  logic                                      i_select_trig,
   input  logic                                      i_manual_trig,
   output logic [CHANNEL_COUNT-1:0]                  o_trig_out,
   output logic [CHANNEL_COUNT-1:0][2:0]             o_trig_state,
   output logic                                      o_busy,
   output logic [CHANNEL_COUNT-1:0]                  o_phase_error
);

   if ((CHANNEL_COUNT < 1) || (CHANNEL_COUNT > MAX_CHANNELS)) begin : g_bad_cfg
      $error("adf4030_trig_scheduler: CHANNEL_COUNT must be in 1..%0d", MAX_CHANNELS);
   end

   logic                     r_manual_q;
   logic                     w_man_edge;
   logic                     r_busy;
   logic [CHANNEL_COUNT-1:0] w_active;
   trig_state_t              w_state [CHANNEL_COUNT];

   assign w_man_edge = i_manual_trig & ~r_manual_q;

   for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_ch
      adf4030_trig_channel #(
         .PHASE_WIDTH (PHASE_WIDTH)
      ) u_ch (
         .i_clk         (i_clk),
         .i_rstn        (i_rstn),
         .i_en          (i_trig_channel_en[g]),
         .i_select_trig (i_select_trig),
         .i_man_edge    (w_man_edge),
         .i_bsync       (i_bsync),
         .i_bsync_ratio (i_bsync_ratio),
         .i_phase       (i_trig_channel_phase[g]),
         .o_trig        (o_trig_out[g]),
         .o_state       (w_state[g]),
         .o_phase_error (o_phase_error[g])
      );

      assign o_trig_state[g] = w_state[g];
      assign w_active[g]     = is_active(w_state[g]);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_manual_q <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_manual_q <= i_manual_trig;
         r_busy     <= |w_active;
      end
   end

   assign o_busy = r_busy;

endmodule

// File: tb/tb_adf4030_trig_scheduler.sv
// Bench for adf4030_trig_scheduler: event-time reference model feeding per-channel pulse queues,
// a negedge monitor that pops and compares, directed scenarios followed by a randomized soak.
module tb_adf4030_trig_scheduler;
   import adf4030_trig_pkg::*;

   localparam int CH = 2;
   localparam int PW = 16;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   bsync = 1'b0;
   logic                   select_trig = 1'b0;
   logic                   manual_trig = 1'b0;
   logic [PW-1:0]          bsync_ratio = '0;
   logic [CH-1:0]          en = '0;
   logic [CH-1:0][PW-1:0]  phase = '0;
   logic [CH-1:0]          trig_out;
   logic [CH-1:0][2:0]     trig_state;
   logic                   busy;
   logic [CH-1:0]          phase_error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_pulse [CH];
   int pulse_cnt [CH];

   typedef enum int {M_IDLE, M_ARMED, M_CNT, M_ERR} mstat_t;
   mstat_t m_stat [CH];
   int     m_fire_at [CH];
   int     exp_q [CH][$];
   logic   m_man_q = 1'b0;
   logic   m_busy = 1'b0;

   adf4030_trig_scheduler #(
      .CHANNEL_COUNT (CH),
      .PHASE_WIDTH   (PW)
   ) dut (
      .i_clk                (clk),
      .i_rstn               (rstn),
      .i_bsync              (bsync),
      .i_bsync_ratio        (bsync_ratio),
      .i_trig_channel_en    (en),
      .i_trig_channel_phase (phase),
      .i_select_trig        (select_trig),
      .i_manual_trig        (manual_trig),
      .o_trig_out           (trig_out),
      .o_trig_state         (trig_state),
      .o_busy               (busy),
      .o_phase_error        (phase_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: inputs of cycle t are sampled at the edge ending it; a bsync
   // seen while armed schedules a pulse at t+1+phase, committed one cycle ahead.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < CH; i++) begin
            m_stat[i]    = M_IDLE;
            m_fire_at[i] = -1;
            exp_q[i].delete();
         end
         m_man_q = 1'b0;
         m_busy  = 1'b0;
      end else begin
         int   t;
         int   lim;
         logic man;
         t   = cyc;
         man = manual_trig & ~m_man_q;
         m_man_q = manual_trig;
         m_busy  = 1'b0;
         for (int i = 0; i < CH; i++)
            if (m_stat[i] == M_ARMED || m_stat[i] == M_CNT) m_busy = 1'b1;
         lim = 2 * int'(bsync_ratio) - 2;
         for (int i = 0; i < CH; i++) begin
            if (!en[i]) begin
               m_stat[i]    = M_IDLE;
               m_fire_at[i] = -1;
            end else begin
               case (m_stat[i])
                  M_IDLE:  if (!select_trig || man) m_stat[i] = M_ARMED;
                  M_ARMED: if (bsync) begin
                     if (bsync_ratio == 0 || int'(phase[i]) > lim) m_stat[i] = M_ERR;
                     else begin
                        m_stat[i]    = M_CNT;
                        m_fire_at[i] = t + 1 + int'(phase[i]);
                     end
                  end
                  M_CNT:   if (t == m_fire_at[i]) begin
                     m_stat[i]    = select_trig ? M_IDLE : M_ARMED;
                     m_fire_at[i] = -1;
                  end
                  default: ;
               endcase
            end
            if (m_stat[i] == M_CNT && m_fire_at[i] == t + 1) exp_q[i].push_back(t + 1);
         end
      end
   end

   function automatic int exp_state(input int i);
      case (m_stat[i])
         M_IDLE:  return 0;
         M_ARMED: return 1;
         M_CNT:   return (cyc == m_fire_at[i]) ? 3 : 2;
         default: return 4;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rstn) begin
         for (int i = 0; i < CH; i++) begin
            int exp_fire;
            exp_fire = (exp_q[i].size() != 0 && exp_q[i][0] == cyc) ? 1 : 0;
            if (exp_fire == 1) void'(exp_q[i].pop_front());
            if (trig_out[i]) begin
               last_pulse[i] = cyc;
               pulse_cnt[i]++;
            end
            chk($sformatf("ch%0d_pulse", i), int'(trig_out[i]), exp_fire);
            chk($sformatf("ch%0d_state", i), int'(trig_state[i]), exp_state(i));
            chk($sformatf("ch%0d_phase_error", i), int'(phase_error[i]), (m_stat[i] == M_ERR) ? 1 : 0);
         end
         chk("busy", int'(busy), int'(m_busy));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic bsync_then(input int n);
      bsync = 1'b1;
      tick();
      bsync = 1'b0;
      repeat (n - 1) tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1);
   end

   initial begin
      int t0;
      int pc;
      int ci;
      for (int i = 0; i < CH; i++) begin
         last_pulse[i] = -1;
         pulse_cnt[i]  = 0;
      end
      repeat (3) tick();
      chk("rst_trig_out", int'(trig_out), 0);
      chk("rst_trig_state", int'(trig_state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_phase_error", int'(phase_error), 0);
      rstn = 1'b1;
      tick();

      bsync_ratio = 16'd10;
      phase[0]    = 16'd5;
      en[0]       = 1'b1;
      repeat (3) tick();
      chk("periodic_armed", int'(trig_state[0]), 1);
      t0 = cyc;
      for (int k = 0; k < 3; k++) begin
         bsync_then(15);
         chk("periodic_gap_armed", int'(trig_state[0]), 1);
         chk("periodic_pulse", last_pulse[0], t0 + 20 * k + 6);
         repeat (5) tick();
      end

      phase[0] = 16'd0;
      t0 = cyc;
      bsync_then(20);
      chk("phase_zero", last_pulse[0], t0 + 1);
      phase[0] = 16'd18;
      t0 = cyc;
      bsync_then(20);
      chk("phase_max", last_pulse[0], t0 + 19);

      phase[0] = 16'd19;
      pc = pulse_cnt[0];
      bsync_then(20);
      chk("err_state", int'(trig_state[0]), 4);
      chk("err_flag", int'(phase_error[0]), 1);
      chk("err_no_pulse", pulse_cnt[0], pc);
      en[0] = 1'b0;
      tick();
      chk("err_clear_state", int'(trig_state[0]), 0);
      chk("err_clear_flag", int'(phase_error[0]), 0);
      en[0] = 1'b1;
      tick();
      chk("err_rearm", int'(trig_state[0]), 1);

      en[0] = 1'b0;
      select_trig = 1'b1;
      tick();
      en[0] = 1'b1;
      repeat (3) tick();
      chk("oneshot_wait_idle", int'(trig_state[0]), 0);
      manual_trig = 1'b1;
      tick();
      tick();
      chk("oneshot_armed", int'(trig_state[0]), 1);
      phase[0] = 16'd3;
      t0 = cyc;
      bsync_then(10);
      chk("oneshot_pulse", last_pulse[0], t0 + 4);
      chk("oneshot_done_idle", int'(trig_state[0]), 0);
      pc = pulse_cnt[0];
      bsync_then(10);
      chk("oneshot_no_repeat", pulse_cnt[0], pc);
      manual_trig = 1'b0;
      tick();
      manual_trig = 1'b1;
      tick();
      tick();
      chk("oneshot_rearm", int'(trig_state[0]), 1);
      t0 = cyc;
      bsync_then(10);
      chk("oneshot_pulse2", last_pulse[0], t0 + 4);

      manual_trig = 1'b0;
      tick();
      pc = pulse_cnt[0];
      manual_trig = 1'b1;
      bsync = 1'b1;
      tick();
      bsync = 1'b0;
      tick();
      chk("edge_with_bsync_armed", int'(trig_state[0]), 1);
      chk("edge_with_bsync_no_pulse", pulse_cnt[0], pc);
      t0 = cyc;
      bsync_then(10);
      chk("edge_with_bsync_pulse", last_pulse[0], t0 + 4);

      select_trig = 1'b0;
      manual_trig = 1'b0;
      phase[0] = 16'd5;
      repeat (2) tick();
      pc = pulse_cnt[0];
      bsync_then(3);
      chk("abort_counting", int'(trig_state[0]), 2);
      en[0] = 1'b0;
      tick();
      chk("abort_idle", int'(trig_state[0]), 0);
      repeat (6) tick();
      chk("abort_no_pulse", pulse_cnt[0], pc);

      en[0] = 1'b1;
      repeat (2) tick();
      t0 = cyc;
      bsync_then(2);
      phase[0] = 16'd9;
      repeat (18) tick();
      chk("phase_latched", last_pulse[0], t0 + 6);

      phase[0] = 16'd5;
      bsync_then(2);
      pc = pulse_cnt[0];
      #2 rstn = 1'b0;
      #1;
      chk("arst_trig_state", int'(trig_state), 0);
      chk("arst_trig_out", int'(trig_out), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_phase_error", int'(phase_error), 0);
      tick();
      rstn = 1'b1;
      tick();
      chk("arst_rearm", int'(trig_state[0]), 1);
      repeat (8) tick();
      chk("arst_no_pulse", pulse_cnt[0], pc);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            ci = int'($urandom_range(0, CH - 1));
            en[ci] = ~en[ci];
         end
         if ($urandom_range(0, 63) == 0) select_trig = ~select_trig;
         if ($urandom_range(0, 5) == 0) manual_trig = ~manual_trig;
         bsync = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0) bsync_ratio = PW'($urandom_range(0, 12));
         if ($urandom_range(0, 15) == 0) begin
            ci = int'($urandom_range(0, CH - 1));
            phase[ci] = PW'($urandom_range(0, 25));
         end
         if (n == 1500) rstn = 1'b0;
         tick();
         rstn = 1'b1;
      end

      bsync = 1'b0;
      en = '0;
      repeat (5) tick();
      for (int i = 0; i < CH; i++) chk($sformatf("ch%0d_drain", i), exp_q[i].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
